sender_fifo: RTL and testbench

- Parametrised successor to the single-word four-phase sender.
- Buffers up to DEPTH words from a producer in an internal FIFO and drains them to a receiver over a Request/Ack four-phase handshake.
- Adds Ack timeout with bounded retry, word drop with an error pulse, and overflow reporting.
- Sits between a local producer and an off-block receiver; one clock domain.

---
 rtl/sender_fifo.sv | 142 ++++++++++++++
 tb/tb_sender_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sender_fifo.sv
// sender_fifo: DEPTH-word FIFO draining to a receiver over a four-phase Request/Ack
// handshake, with Ack timeout, bounded retry, word drop (Error) and Overflow reporting.
`timescale 1ns/1ps
`default_nettype none

module sender_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     Transmit,
  input  logic [WIDTH-1:0]         DataIn,
  input  logic                     Ack,
  output logic                     Ready,
  output logic                     Request,
  output logic [WIDTH-1:0]         DataOut,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;
  localparam logic [1:0] BACKOFF  = 2'd3;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [RW-1:0]    retry;

  logic full;
  logic push;
  logic pop;
  logic timed_out;
  logic give_up;

  assign full      = (Count == FULL_COUNT);
  assign Ready     = !full;
  assign push      = Transmit && !full;
  assign timed_out = (state == REQ) && !Ack && (timer == TIMER_LAST);
  assign give_up   = timed_out && !(retry < RETRY_MAX);
  // Ack on the timeout edge still counts as a successful transfer.
  assign pop       = (state == REQ) && (Ack || give_up);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= DataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      Overflow <= Transmit && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      Request <= 1'b0;
      DataOut <= '0;
      Error   <= 1'b0;
      timer   <= '0;
      retry   <= '0;
    end else begin
      Error <= 1'b0;
      case (state)
        IDLE: begin
          if (Count != '0) begin
            DataOut <= mem[rd_ptr];
            Request <= 1'b1;
            timer   <= '0;
            retry   <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (Ack) begin
            Request <= 1'b0;
            state   <= WAIT_LOW;
          end else if (timed_out) begin
            Request <= 1'b0;
            if (give_up) begin
              Error <= 1'b1;
              state <= IDLE;
            end else begin
              retry <= retry + 1'b1;
              state <= BACKOFF;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BACKOFF: begin
          Request <= 1'b1;
          timer   <= '0;
          state   <= REQ;
        end
        WAIT_LOW: begin
          if (!Ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sender_fifo.sv
// tb_sender_fifo: directed scoreboard bench for sender_fifo (default parameters).
`timescale 1ns/1ps
`default_nettype none

module tb_sender_fifo;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Transmit = 1'b0;
  logic [15:0] DataIn = '0;
  logic        Ack = 1'b0;
  logic        Ready;
  logic        Request;
  logic [15:0] DataOut;
  logic [2:0]  Count;
  logic        Overflow;
  logic        Error;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb[$];

  sender_fifo #(.WIDTH(16), .DEPTH(4), .TIMEOUT(8), .MAX_RETRY(2)) dut (
    .clk(clk), .Reset(Reset), .Transmit(Transmit), .DataIn(DataIn), .Ack(Ack),
    .Ready(Ready), .Request(Request), .DataOut(DataOut), .Count(Count),
    .Overflow(Overflow), .Error(Error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    Transmit = 1'b1;
    DataIn   = w;
    if (Ready === 1'b1) sb.push_back(w);
    tick();
    Transmit = 1'b0;
  endtask

  function automatic logic [15:0] sb_pop();
    if (sb.size() == 0) return 16'hxxxx;
    return sb.pop_front();
  endfunction

  // Complete one four-phase handshake and score the word against the queue.
  task automatic receive();
    for (int n = 0; n < 40 && Request !== 1'b1; n++) tick();
    check("req_rise", {31'd0, Request}, 32'd1);
    check("data_out", {16'd0, DataOut}, {16'd0, sb_pop()});
    Ack = 1'b1;
    tick();
    check("req_fall", {31'd0, Request}, 32'd0);
    Ack = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] exp_word;
    logic        exp_req;

    // Reset state
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_request", {31'd0, Request}, 32'd0);
    check("rst_count", {29'd0, Count}, 32'd0);
    check("rst_ready", {31'd0, Ready}, 32'd1);
    check("rst_overflow", {31'd0, Overflow}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_dataout", {16'd0, DataOut}, 32'd0);

    // Single word, basic handshake and latency
    push(16'h0010);
    check("t1_count_after_push", {29'd0, Count}, 32'd1);
    check("t1_req_not_yet", {31'd0, Request}, 32'd0);
    tick();
    check("t1_req_rise", {31'd0, Request}, 32'd1);
    check("t1_dataout", {16'd0, DataOut}, {16'd0, sb_pop()});
    Ack = 1'b1;
    tick();
    check("t1_req_fall", {31'd0, Request}, 32'd0);
    check("t1_count_pop", {29'd0, Count}, 32'd0);
    tick();
    check("t1_req_hold_low", {31'd0, Request}, 32'd0);
    Ack = 1'b0;
    tick();
    check("t1_idle_req", {31'd0, Request}, 32'd0);

    // Fill to full, overflow, then drain in order
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        check("t2_ready_full", {31'd0, Ready}, 32'd0);
        check("t2_count_full", {29'd0, Count}, 32'd4);
      end
      push(16'h0010 + 16'(i));
    end
    check("t2_overflow", {31'd0, Overflow}, 32'd1);
    check("t2_count_stays", {29'd0, Count}, 32'd4);
    tick();
    check("t2_overflow_pulse", {31'd0, Overflow}, 32'd0);
    for (int i = 0; i < 4; i++) receive();
    check("t2_drained", {29'd0, Count}, 32'd0);

    // No Ack: three 8-cycle attempts with one-cycle gaps, then drop with Error
    push(16'h00A5);
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_req = ((k - 1) / 9 < 3) && ((k - 1) % 9 < 8);
      check($sformatf("t3_req_k%0d", k), {31'd0, Request}, {31'd0, exp_req});
      check($sformatf("t3_err_k%0d", k), {31'd0, Error}, {31'd0, (k == 27)});
      check($sformatf("t3_cnt_k%0d", k), {29'd0, Count}, (k < 27) ? 32'd1 : 32'd0);
      if (k == 27) void'(sb_pop());
    end

    // Ack on the last cycle of the second attempt wins over the timeout
    push(16'h005A);
    for (int k = 1; k <= 16; k++) tick();
    tick();
    check("t4_req_attempt2_end", {31'd0, Request}, 32'd1);
    Ack = 1'b1;
    tick();
    check("t4_req_fall", {31'd0, Request}, 32'd0);
    check("t4_no_error", {31'd0, Error}, 32'd0);
    check("t4_count_pop", {29'd0, Count}, 32'd0);
    check("t4_dataout", {16'd0, DataOut}, {16'd0, sb_pop()});
    Ack = 1'b0;
    tick();
    check("t4_no_error_after", {31'd0, Error}, 32'd0);
    tick();

    // Reset in REQ with three queued words
    push(16'h0031);
    push(16'h0032);
    push(16'h0033);
    check("t5_count3", {29'd0, Count}, 32'd3);
    check("t5_in_req", {31'd0, Request}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    sb.delete();
    check("t5_req_cleared", {31'd0, Request}, 32'd0);
    check("t5_count_cleared", {29'd0, Count}, 32'd0);
    check("t5_ready", {31'd0, Ready}, 32'd1);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    tick();
    check("t5_ack_ignored_req", {31'd0, Request}, 32'd0);
    check("t5_ack_ignored_cnt", {29'd0, Count}, 32'd0);
    tick();
    check("t5_still_idle", {31'd0, Request}, 32'd0);

    // Simultaneous push and pop at Count=2
    push(16'h0020);
    push(16'h0021);
    check("t6_count2", {29'd0, Count}, 32'd2);
    check("t6_req", {31'd0, Request}, 32'd1);
    exp_word = sb_pop();
    check("t6_dataout", {16'd0, DataOut}, {16'd0, exp_word});
    Ack      = 1'b1;
    Transmit = 1'b1;
    DataIn   = 16'h0022;
    sb.push_back(16'h0022);
    tick();
    Transmit = 1'b0;
    check("t6_count_same", {29'd0, Count}, 32'd2);
    check("t6_req_fall", {31'd0, Request}, 32'd0);
    Ack = 1'b0;
    tick();
    receive();
    receive();
    check("t6_drained", {29'd0, Count}, 32'd0);

    // Pointer wrap: 2*DEPTH sequential transfers
    for (int i = 0; i < 8; i++) begin
      push(16'(i));
      receive();
    end
    check("t7_final_count", {29'd0, Count}, 32'd0);
    check("t7_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
